// File: rtl/btn_enc_pkg.sv
// btn_enc_pkg: shared constants, FSM state type and helpers for the
// button encoder front-end.
package btn_enc_pkg;

    localparam int NUM_BTN = 4;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } btn_enc_state_t;

    // True when at most one bit of v is set.
    function automatic logic onehot_or_zero(input logic [NUM_BTN-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < NUM_BTN; i++) begin
            n = n + 32'(v[i]);
        end
        return (n <= 1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: one button line. A 2-flop synchroniser feeds a
// debouncer that only moves its level after DEBOUNCE_CYCLES consecutive
// synchronised samples disagree with it.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic deb
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          s1;
    logic          s;
    logic [CW-1:0] cnt;

    // Two-stage synchroniser for the asynchronous button level.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s  <= 1'b0;
        end else begin
            s1 <= raw;
            s  <= s1;
        end
    end

    // Stability counter: any agreement restarts the count, so a glitch
    // shorter than DEBOUNCE_CYCLES samples never reaches the level.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            deb <= 1'b0;
        end else if (s == deb) begin
            cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            deb <= s;
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/btn_encoder.sv
// btn_encoder: debounces four raw buttons and turns each accepted press
// into a one-cycle one-hot btn strobe, or a one-cycle invalid strobe for
// a multi-button press. After a press the encoder stays locked (busy)
// until every button is released.
// Optional feature: define BTN_ENC_REPEAT_EN to re-emit the held single
// button every REPEAT_CYCLES cycles while locked.
//
// Output contract: btn and invalid are registered, fire-and-forget
// strobes with no handshake; the consumer samples them every cycle and
// they are never high together. busy reflects the FSM state (LOCK).
module btn_encoder
    import btn_enc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_CYCLES   = 50
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] raw_btn,
    output logic [NUM_BTN-1:0] btn,
    output logic               invalid,
    output logic               busy
);

    logic [NUM_BTN-1:0] deb;
    logic [NUM_BTN-1:0] deb_q;
    logic [NUM_BTN-1:0] rise;
    logic [NUM_BTN-1:0] btn_n;
    logic               invalid_n;
    btn_enc_state_t     state;
    btn_enc_state_t     state_n;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_deb
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk(clk),
            .rst(rst),
            .raw(raw_btn[i]),
            .deb(deb[i])
        );
    end

    assign rise = deb & ~deb_q;
    assign busy = (state == LOCK);

`ifdef BTN_ENC_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES);

    logic [RW-1:0] rcnt;
    logic [RW-1:0] rcnt_n;
`else
    // Parameter kept for a uniform interface; no repeat logic is built.
    logic unused_repeat;
    assign unused_repeat = (REPEAT_CYCLES > 1);
`endif

    // State, strobe and history registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            btn     <= '0;
            invalid <= 1'b0;
            deb_q   <= '0;
`ifdef BTN_ENC_REPEAT_EN
            rcnt    <= '0;
`endif
        end else begin
            state   <= state_n;
            btn     <= btn_n;
            invalid <= invalid_n;
            deb_q   <= deb;
`ifdef BTN_ENC_REPEAT_EN
            rcnt    <= rcnt_n;
`endif
        end
    end

    // Next-state and strobe decode; strobes default low so each lasts
    // exactly one cycle.
    always_comb begin
        state_n   = state;
        btn_n     = '0;
        invalid_n = 1'b0;
`ifdef BTN_ENC_REPEAT_EN
        rcnt_n    = '0;
`endif
        case (state)
            IDLE: begin
                // Any rise implies deb is nonzero, so onehot_or_zero here
                // means exactly one button is down.
                if (rise != '0) begin
                    if (onehot_or_zero(deb)) begin
                        btn_n = deb;
                    end else begin
                        invalid_n = 1'b1;
                    end
                    state_n = LOCK;
                end
            end
            LOCK: begin
                if (deb == '0) begin
                    state_n = IDLE;
                end
`ifdef BTN_ENC_REPEAT_EN
                else if (onehot_or_zero(deb) && (deb == deb_q)) begin
                    if (rcnt == RW'(REPEAT_CYCLES - 1)) begin
                        btn_n  = deb;
                        rcnt_n = '0;
                    end else begin
                        rcnt_n = rcnt + 1'b1;
                    end
                end
`endif
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
